// File: rtl/writeback_queue_pkg.sv
// Constants and types shared by the write-back path, the register file and decode.
// Round-robin encoding and the arbiter's pointer-update rule live here as well.
package writeback_queue_pkg;

   localparam int REG_ADDR_W = 4;
   localparam int REG_COUNT  = 16;

   typedef enum logic {
      RR_MEM = 1'b0,
      RR_ALU = 1'b1
   } rr_e;

   // After a contested grant the priority moves to the source that lost.
   function automatic rr_e rr_loser(input logic granted_alu);
      rr_e v_next;
      if (granted_alu) begin
         v_next = RR_MEM;
      end else begin
         v_next = RR_ALU;
      end
      return v_next;
   endfunction

endpackage

// File: rtl/writeback_queue_fifo.sv
// Circular buffer for write-back entries: storage, head/tail pointers and occupancy.
// Clear discards the contents by resetting pointers and count; storage keeps stale data.
module writeback_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_asynchronous_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_clear,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [CW-1:0]    r_count;

   // Entry storage; written only at the tail on an accepted push.
   always_ff @(posedge clk or negedge reset_asynchronous_n) begin
      if (!reset_asynchronous_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {WIDTH{1'b0}};
         end
      end else if (i_push && !i_clear) begin
         r_mem[r_tail] <= i_data;
      end else begin
         r_mem[r_tail] <= r_mem[r_tail];
      end
   end

   // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_asynchronous_n) begin
      if (!reset_asynchronous_n) begin
         r_head  <= {PW{1'b0}};
         r_tail  <= {PW{1'b0}};
         r_count <= {CW{1'b0}};
      end else if (i_clear) begin
         r_head  <= {PW{1'b0}};
         r_tail  <= {PW{1'b0}};
         r_count <= {CW{1'b0}};
      end else begin
         if (i_push) begin
            r_tail <= r_tail + PW'(1);
         end else begin
            r_tail <= r_tail;
         end
         if (i_pop) begin
            r_head <= r_head + PW'(1);
         end else begin
            r_head <= r_head;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_head];
   assign o_count = r_count;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == {CW{1'b0}});

endmodule

// File: rtl/writeback_queue.sv
// Write-back queue: round-robin arbitration of ALU and load writes into a FIFO that
// drains one entry per cycle into the register file write port.
module writeback_queue
   import writeback_queue_pkg::*;
#(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_asynchronous_n,
   input  logic                     inp_flush,
   input  logic                     inp_hold,
   input  logic                     inp_alu_valid,
   input  logic [REG_ADDR_W-1:0]    inp_alu_address,
   input  logic [W-1:0]             inp_alu_data,
   output logic                     out_alu_ready,
   input  logic                     inp_mem_valid,
   input  logic [REG_ADDR_W-1:0]    inp_mem_address,
   input  logic [W-1:0]             inp_mem_data,
   output logic                     out_mem_ready,
   output logic                     out_write_enable,
   output logic [REG_ADDR_W-1:0]    out_write_address,
   output logic [W-1:0]             out_write_data,
   output logic [$clog2(DEPTH):0]   out_count,
   output logic                     out_full,
   output logic                     out_empty
);

   localparam int EW = W + REG_ADDR_W;

   rr_e           r_rr;
   logic          w_deq;
   logic          w_space;
   logic          w_open;
   logic          w_contested;
   logic          w_grant_alu;
   logic          w_grant_mem;
   logic          w_push;
   logic [EW-1:0] w_push_data;
   logic [EW-1:0] w_head;

   assign w_deq       = !out_empty && !inp_hold && !inp_flush;
   assign w_space     = !out_full || w_deq;
   // Readies must read low while reset is held, even though an empty queue has space.
   assign w_open      = w_space && !inp_flush && reset_asynchronous_n;
   assign w_contested = inp_alu_valid && inp_mem_valid;

   // Grant selection: a lone requester wins, a tie goes to the round-robin favourite.
   always_comb begin
      w_grant_alu = 1'b0;
      w_grant_mem = 1'b0;
      if (w_open) begin
         if (w_contested) begin
            if (r_rr == RR_ALU) begin
               w_grant_alu = 1'b1;
            end else begin
               w_grant_mem = 1'b1;
            end
         end else if (inp_alu_valid) begin
            w_grant_alu = 1'b1;
         end else if (inp_mem_valid) begin
            w_grant_mem = 1'b1;
         end else begin
            w_grant_alu = 1'b0;
            w_grant_mem = 1'b0;
         end
      end else begin
         w_grant_alu = 1'b0;
         w_grant_mem = 1'b0;
      end
   end

   assign out_alu_ready = w_open && ((r_rr == RR_ALU) || !inp_mem_valid);
   assign out_mem_ready = w_open && ((r_rr == RR_MEM) || !inp_alu_valid);

   assign w_push      = w_grant_alu || w_grant_mem;
   assign w_push_data = w_grant_alu ? {inp_alu_address, inp_alu_data}
                                    : {inp_mem_address, inp_mem_data};

   // Round-robin pointer: moves only on a contested grant, cleared by flush.
   always_ff @(posedge clk or negedge reset_asynchronous_n) begin
      if (!reset_asynchronous_n) begin
         r_rr <= RR_MEM;
      end else if (inp_flush) begin
         r_rr <= RR_MEM;
      end else if (w_push && w_contested) begin
         r_rr <= rr_loser(w_grant_alu);
      end else begin
         r_rr <= r_rr;
      end
   end

   writeback_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk                  (clk),
      .reset_asynchronous_n (reset_asynchronous_n),
      .i_push               (w_push),
      .i_pop                (w_deq),
      .i_clear              (inp_flush),
      .i_data               (w_push_data),
      .o_data               (w_head),
      .o_count              (out_count),
      .o_full               (out_full),
      .o_empty              (out_empty)
   );

   assign out_write_enable  = w_deq;
   assign out_write_address = w_head[EW-1:W];
   assign out_write_data    = w_head[W-1:0];

endmodule

// File: tb/tb_writeback_queue.sv
// Directed self-checking bench for writeback_queue; writes are logged on the falling
// edge and compared against hand-computed sequences.
module tb_writeback_queue;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        hold;
   logic        alu_valid;
   logic [3:0]  alu_addr;
   logic [15:0] alu_data;
   logic        alu_ready;
   logic        mem_valid;
   logic [3:0]  mem_addr;
   logic [15:0] mem_data;
   logic        mem_ready;
   logic        we;
   logic [3:0]  waddr;
   logic [15:0] wdata;
   logic [2:0]  count;
   logic        full;
   logic        empty;

   int n_checks;
   int n_fail;
   logic [19:0] wlog[$];

   writeback_queue #(.W(16), .DEPTH(4)) dut (
      .clk                  (clk),
      .reset_asynchronous_n (rst_n),
      .inp_flush            (flush),
      .inp_hold             (hold),
      .inp_alu_valid        (alu_valid),
      .inp_alu_address      (alu_addr),
      .inp_alu_data         (alu_data),
      .out_alu_ready        (alu_ready),
      .inp_mem_valid        (mem_valid),
      .inp_mem_address      (mem_addr),
      .inp_mem_data         (mem_data),
      .out_mem_ready        (mem_ready),
      .out_write_enable     (we),
      .out_write_address    (waddr),
      .out_write_data       (wdata),
      .out_count            (count),
      .out_full             (full),
      .out_empty            (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The register file captures at the next rising edge; inputs are stable from here to there.
   always @(negedge clk) begin
      if (we) wlog.push_back({waddr, wdata});
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain_all();
      for (int k = 0; k < 12; k++) begin
         if (empty) break;
         step();
      end
      check_eq("drain_done", 32'(empty), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      int cyc;
      int bad;
      logic acc;
      n_checks = 0;
      n_fail   = 0;
      rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
      alu_valid = 1'b1; alu_addr = 4'd0; alu_data = 16'h0000;
      mem_valid = 1'b0; mem_addr = 4'd0; mem_data = 16'h0000;

      // Reset state, readies forced low even with a valid request.
      #12;
      check_eq("rst_alu_ready", 32'(alu_ready), 32'd0);
      check_eq("rst_mem_ready", 32'(mem_ready), 32'd0);
      check_eq("rst_count", 32'(count), 32'd0);
      check_eq("rst_empty", 32'(empty), 32'd1);
      check_eq("rst_full", 32'(full), 32'd0);
      check_eq("rst_we", 32'(we), 32'd0);
      check_eq("rst_addr_data", 32'({waddr, wdata}), 32'd0);

      // Single ALU write.
      step();
      rst_n = 1'b1; alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 16'h00A5;
      @(negedge clk);
      check_eq("t1_alu_ready", 32'(alu_ready), 32'd1);
      step();
      alu_valid = 1'b0;
      @(negedge clk);
      check_eq("t1_we", 32'(we), 32'd1);
      check_eq("t1_addr", 32'(waddr), 32'd3);
      check_eq("t1_data", 32'(wdata), 32'h00A5);
      step();
      @(negedge clk);
      check_eq("t1_empty_after", 32'(empty), 32'd1);
      check_eq("t1_we_after", 32'(we), 32'd0);

      // Both sources every cycle: grants alternate starting with memory.
      step();
      wlog.delete();
      alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 16'h1111;
      mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 16'h2222;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_eq("t2_mem_ready", 32'(mem_ready), 32'((i % 2) == 0));
         check_eq("t2_alu_ready", 32'(alu_ready), 32'((i % 2) == 1));
         check_eq("t2_count_le1", 32'(count <= 3'd1), 32'd1);
         step();
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      drain_all();
      check_eq("t2_nwrites", 32'(wlog.size()), 32'd6);
      bad = 0;
      for (int k = 0; k < 6 && k < wlog.size(); k++) begin
         if (wlog[k] !== (((k % 2) == 0) ? {4'd2, 16'h2222} : {4'd1, 16'h1111})) bad++;
      end
      check_eq("t2_order", 32'(bad), 32'd0);

      // Fill under hold, then drain-and-accept while full.
      wlog.delete();
      hold = 1'b1; alu_valid = 1'b1; alu_addr = 4'd7;
      for (int i = 1; i <= 4; i++) begin
         alu_data = 16'(i);
         step();
      end
      alu_data = 16'h0005;
      @(negedge clk);
      check_eq("t3_full", 32'(full), 32'd1);
      check_eq("t3_count", 32'(count), 32'd4);
      check_eq("t3_ready_held", 32'(alu_ready), 32'd0);
      check_eq("t3_head_data", 32'(wdata), 32'h0001);
      step();
      @(negedge clk);
      check_eq("t3_stable_count", 32'(count), 32'd4);
      check_eq("t3_stable_we", 32'(we), 32'd0);
      step();
      hold = 1'b0;
      @(negedge clk);
      check_eq("t3_ready_full_drain", 32'(alu_ready), 32'd1);
      step();
      alu_valid = 1'b0;
      @(negedge clk);
      check_eq("t3_count_kept", 32'(count), 32'd4);
      drain_all();
      check_eq("t3_nwrites", 32'(wlog.size()), 32'd5);
      bad = 0;
      for (int k = 0; k < 5 && k < wlog.size(); k++) begin
         if (wlog[k] !== {4'd7, 16'(k + 1)}) bad++;
      end
      check_eq("t3_order", 32'(bad), 32'd0);

      // Pointer wrap: ten pushes with hold toggling every cycle.
      wlog.delete();
      idx = 0; cyc = 0;
      while (idx < 10 && cyc < 60) begin
         hold = cyc[0];
         alu_valid = 1'b1; alu_addr = 4'(idx); alu_data = 16'h0100 + 16'(idx);
         @(negedge clk);
         acc = alu_ready;
         step();
         if (acc) idx++;
         cyc++;
      end
      alu_valid = 1'b0; hold = 1'b0;
      check_eq("t4_pushed", 32'(idx), 32'd10);
      drain_all();
      check_eq("t4_nwrites", 32'(wlog.size()), 32'd10);
      bad = 0;
      for (int k = 0; k < 10 && k < wlog.size(); k++) begin
         if (wlog[k] !== {4'(k), 16'h0100 + 16'(k)}) bad++;
      end
      check_eq("t4_order", 32'(bad), 32'd0);

      // Flush with three queued entries and rr pointing at ALU.
      hold = 1'b1;
      alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 16'h0C01;
      mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 16'h0D02;
      @(negedge clk);
      check_eq("t5_first_mem", 32'(mem_ready), 32'd1);
      step();
      mem_valid = 1'b0;
      step();
      step();
      alu_valid = 1'b0; hold = 1'b0; flush = 1'b1;
      mem_valid = 1'b1; mem_addr = 4'd9; mem_data = 16'h0E09;
      wlog.delete();
      @(negedge clk);
      check_eq("t5_count_pre", 32'(count), 32'd3);
      check_eq("t5_flush_we", 32'(we), 32'd0);
      check_eq("t5_flush_mem_ready", 32'(mem_ready), 32'd0);
      check_eq("t5_flush_alu_ready", 32'(alu_ready), 32'd0);
      step();
      flush = 1'b0; alu_valid = 1'b1;
      @(negedge clk);
      check_eq("t5_count_post", 32'(count), 32'd0);
      check_eq("t5_empty_post", 32'(empty), 32'd1);
      check_eq("t5_rr_mem", 32'(mem_ready), 32'd1);
      check_eq("t5_rr_alu", 32'(alu_ready), 32'd0);
      step();
      mem_valid = 1'b0; alu_valid = 1'b0;
      @(negedge clk);
      check_eq("t5_retry_write", 32'({we, waddr, wdata}), 32'({1'b1, 4'd9, 16'h0E09}));
      step();
      check_eq("t5_nwrites", 32'(wlog.size()), 32'd1);

      // Asynchronous reset in the middle of a drain.
      hold = 1'b1; alu_valid = 1'b1;
      alu_addr = 4'd5; alu_data = 16'h0AAA;
      step();
      alu_addr = 4'd6; alu_data = 16'h0BBB;
      step();
      alu_valid = 1'b0; hold = 1'b0;
      @(negedge clk);
      check_eq("t6_count_pre", 32'(count), 32'd2);
      check_eq("t6_we_pre", 32'(we), 32'd1);
      #2;
      rst_n = 1'b0; alu_valid = 1'b1; mem_valid = 1'b1;
      #1;
      wlog.delete();
      check_eq("t6_we_rst", 32'(we), 32'd0);
      check_eq("t6_addr_data_rst", 32'({waddr, wdata}), 32'd0);
      check_eq("t6_count_rst", 32'(count), 32'd0);
      check_eq("t6_readies_rst", 32'({alu_ready, mem_ready}), 32'd0);
      step();
      rst_n = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
      repeat (3) step();
      check_eq("t6_no_stale", 32'(wlog.size()), 32'd0);
      check_eq("t6_count_post", 32'(count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
